// File: rtl/tc_sram_tiled_pkg.sv
// Shared types and helpers for the tiled SRAM.
//   state_e     : controller state (IDLE accepts requests, MERGE writes back an RMW)
//   ceil_div    : integer ceiling division used for the tile grid geometry
//   be_to_mask  : expands byte enables into a per-bit write mask; the last
//                 byte may be narrower than byte_w when data_w is not a multiple
package tc_sram_tiled_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // Upper bounds for the mask helper; callers truncate to their own width.
  localparam int unsigned MaxDataWidth = 1024;
  localparam int unsigned MaxBeWidth   = 1024;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic logic [MaxDataWidth-1:0] be_to_mask(
    input logic [MaxBeWidth-1:0] be,
    input int unsigned           byte_w,
    input int unsigned           data_w
  );
    logic [MaxDataWidth-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxDataWidth; i++) begin
      if (i < data_w) mask[10'(i)] = be[10'(i / byte_w)];
    end
    return mask;
  endfunction

endpackage

// File: rtl/tc_sram_tile.sv
// One MacroWords x MacroWidth single-port tile.
// Behavioural stand-in for the ASAP7 SRAM macro of the same geometry: the
// implementation flow swaps this body for the macro, which has the same
// active-low chip/write enables and one-cycle registered read.
// Ports:
//   clk_i   : clock
//   ce_ni   : chip enable, active low
//   we_ni   : write enable, active low (read when high and ce_ni low)
//   addr_i  : word address inside the tile
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read, held otherwise
module tc_sram_tile #(
  parameter int unsigned MacroWords = 256,
  parameter int unsigned MacroWidth = 64,
  localparam int unsigned TileAw    = (MacroWords > 1) ? $clog2(MacroWords) : 1
) (
  input  logic                  clk_i,
  input  logic                  ce_ni,
  input  logic                  we_ni,
  input  logic [TileAw-1:0]     addr_i,
  input  logic [MacroWidth-1:0] wdata_i,
  output logic [MacroWidth-1:0] rdata_o
);

  logic [MacroWidth-1:0] mem_q [MacroWords];
  logic [MacroWidth-1:0] rdata_q;

  // Array and output latch are macro storage: deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (!ce_ni) begin
      if (!we_ni) mem_q[addr_i] <= wdata_i;
      else        rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tc_sram_tiled.sv
// Generic single-port SRAM built from a RowTiles x ColTiles grid of tiles.
// Byte enables are emulated with a two-cycle read-modify-write because the
// tiles have no byte-enable pins.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i / gnt_o : request handshake; a transfer happens on req_i & gnt_o.
//                   gnt_o depends on state only (1 in IDLE, 0 in MERGE), so a
//                   requester simply holds req_i and its payload until granted.
//   we_i, addr_i, wdata_i, be_i : transfer payload
//   rvalid_o, rdata_o : read response one cycle after an accepted read;
//                   rdata_o holds its last value when no read completes
//   err_o         : one-cycle pulse after an accepted out-of-range request
module tc_sram_tiled
  import tc_sram_tiled_pkg::*;
#(
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned ByteWidth  = 8,
  parameter int unsigned MacroWords = 256,
  parameter int unsigned MacroWidth = 64,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth   = ceil_div(DataWidth, ByteWidth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o
);

  localparam int unsigned ColTiles = ceil_div(DataWidth, MacroWidth);
  localparam int unsigned RowTiles = ceil_div(NumWords, MacroWords);
  localparam int unsigned TileAw   = (MacroWords > 1) ? $clog2(MacroWords) : 1;
  localparam int unsigned RowW     = (RowTiles > 1) ? $clog2(RowTiles) : 1;
  localparam int unsigned PadWidth = ColTiles * MacroWidth;

  state_e state_q, state_d;

  // Request decode
  logic                 accept, in_range, be_all, be_none;
  logic [TileAw-1:0]    tile_addr;
  logic [RowW-1:0]      row_idx;
  logic [DataWidth-1:0] be_mask;
  logic [RowTiles-1:0]  req_row_hit, cap_row_hit;

  // Tile drive
  logic [RowTiles-1:0]  row_ce;
  logic                 tile_we, cap_en;
  logic [TileAw-1:0]    tile_a;
  logic [PadWidth-1:0]  tile_wd;
  logic [MacroWidth-1:0] tile_rdata [RowTiles][ColTiles];
  logic [PadWidth-1:0]  merge_src, read_src;
  logic [DataWidth-1:0] merged, rdata_cur;

  // RMW capture and read-response registers
  logic [TileAw-1:0]    addr_q, addr_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] mask_q, mask_d;
  logic                 rvalid_q, rvalid_d;
  logic [RowW-1:0]      rd_row_q, rd_row_d;
  logic                 rd_oor_q, rd_oor_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  always_comb begin
    accept    = req_i && (state_q == IDLE);
    in_range  = (32'(addr_i) < NumWords);
    be_all    = &be_i;
    be_none   = ~|be_i;
    tile_addr = TileAw'(addr_i);
    row_idx   = RowW'(addr_i >> TileAw);
    be_mask   = DataWidth'(be_to_mask(MaxBeWidth'(be_i), ByteWidth, DataWidth));
  end

  always_comb begin
    req_row_hit = '0;
    cap_row_hit = '0;
    for (int r = 0; r < RowTiles; r++) begin
      req_row_hit[r] = (row_idx == RowW'(r));
      cap_row_hit[r] = (row_q == RowW'(r));
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state. Only an in-range partial write needs the MERGE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && in_range && we_i && !be_all && !be_none) state_d = MERGE;
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs and tile control
  always_comb begin
    gnt_o   = 1'b0;
    row_ce  = '0;
    tile_we = 1'b0;
    tile_a  = tile_addr;
    tile_wd = PadWidth'(wdata_i);
    cap_en  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_o = 1'b1;
        if (accept && in_range) begin
          if (!we_i) begin
            row_ce = req_row_hit;
          end else if (be_all) begin
            row_ce  = req_row_hit;
            tile_we = 1'b1;
          end else if (!be_none) begin
            // RMW read phase: tiles read the old word, payload is captured.
            row_ce = req_row_hit;
            cap_en = 1'b1;
          end
        end
      end
      MERGE: begin
        row_ce  = cap_row_hit;
        tile_we = 1'b1;
        tile_a  = addr_q;
        tile_wd = PadWidth'(merged);
      end
      default: ;
    endcase
  end

  for (genvar r = 0; r < RowTiles; r++) begin : g_row
    for (genvar c = 0; c < ColTiles; c++) begin : g_col
      tc_sram_tile #(
        .MacroWords (MacroWords),
        .MacroWidth (MacroWidth)
      ) u_tile (
        .clk_i   (clk_i),
        .ce_ni   (~row_ce[r]),
        .we_ni   (~tile_we),
        .addr_i  (tile_a),
        .wdata_i (tile_wd[c*MacroWidth +: MacroWidth]),
        .rdata_o (tile_rdata[r][c])
      );
    end
  end

  // Row muxes: one for the RMW merge source, one for the read response.
  always_comb begin
    merge_src = '0;
    read_src  = '0;
    for (int r = 0; r < RowTiles; r++) begin
      for (int c = 0; c < ColTiles; c++) begin
        if (row_q == RowW'(r))    merge_src[c*MacroWidth +: MacroWidth] = tile_rdata[r][c];
        if (rd_row_q == RowW'(r)) read_src[c*MacroWidth +: MacroWidth]  = tile_rdata[r][c];
      end
    end
  end

  always_comb begin
    merged = (DataWidth'(merge_src) & ~mask_q) | (wdata_q & mask_q);
    // Tile outputs also move on RMW reads, so the response is taken from the
    // tiles only in the rvalid cycle and from the hold register otherwise.
    if (rvalid_q) rdata_cur = rd_oor_q ? '0 : DataWidth'(read_src);
    else          rdata_cur = rdata_q;
  end

  always_comb begin
    addr_d  = addr_q;
    row_d   = row_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    if (cap_en) begin
      addr_d  = tile_addr;
      row_d   = row_idx;
      wdata_d = wdata_i;
      mask_d  = be_mask;
    end
    rvalid_d = accept && !we_i;
    rd_row_d = rvalid_d ? row_idx : rd_row_q;
    rd_oor_d = rvalid_d ? !in_range : rd_oor_q;
    err_d    = accept && !in_range;
    rdata_d  = rdata_cur;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      row_q    <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rvalid_q <= 1'b0;
      rd_row_q <= '0;
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      row_q    <= row_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rvalid_q <= rvalid_d;
      rd_row_q <= rd_row_d;
      rd_oor_q <= rd_oor_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_cur;
  assign err_o    = err_q;

endmodule
